load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width (only 32 supported).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-003 SHALL have parameter MEM_BYTES, default 16384, size of downstream byte memory.
REQ-004 SHALL have ports, one per line:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  pipeline access request.
- req_ready  out  1  request accepted when both high.
- req_we  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  zero-extend loads when 1, sign-extend when 0.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, LSB-aligned.
- resp_valid  out  1  response available.
- resp_ready  in  1  response consumed when both high.
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- resp_err  out  1  access faulted; no memory write performed.
- mem_en  out  1  memory enable.
- mem_rd_wr  out  1  1=read, 0=write.
- mem_read_addr  out  ADDR_WIDTH  word-aligned read address.
- mem_write_addr  out  ADDR_WIDTH  word-aligned write address.
- mem_write_data  out  DATA_WIDTH  full merged word, little-endian.
- mem_read_data  in  DATA_WIDTH  combinational read data from memory.

Function
REQ-005 SHALL implement FSM states IDLE, READ, WRITE, RESP; mem_* and handshake outputs SHALL decode from registered state and captured request only.
REQ-006 IDLE: req_ready=1, mem_en=0; on req_valid capture req_*, compute aligned address A = req_addr & ~3, lane = req_addr[1:0].
REQ-007 From IDLE: fault -> RESP; load or byte/half store -> READ; word store -> WRITE.
REQ-008 Fault = req_size==11, or A+4 > MEM_BYTES, or misalignment (REQ-019); faulting accesses SHALL never assert mem_en.
REQ-009 READ: mem_en=1, mem_rd_wr=1, mem_read_addr=A for exactly one cycle; mem_read_data sampled at that cycle's end.
REQ-010 Load in READ: extract byte/half at lane, extend per req_unsigned, register into resp_rdata, -> RESP.
REQ-011 Sub-word store in READ: replace addressed byte(s) of sampled word with req_wdata[7:0] or [15:0], -> WRITE.
REQ-012 WRITE: mem_en=1, mem_rd_wr=0, mem_write_addr=A, mem_write_data=merged word for exactly one cycle, -> RESP.
REQ-013 RESP: resp_valid=1, outputs held stable until resp_ready; on resp_ready -> IDLE; req_ready=0 in all non-IDLE states.
REQ-014 Latency from acceptance edge to resp_valid: fault 1 cycle, load 2, word store 2, sub-word store 3.
REQ-015 No new request accepted in the cycle resp handshake completes (IDLE always intervenes); one access in flight maximum.
REQ-016 Unused address outputs SHALL hold A; mem_write_data SHALL be 0 outside WRITE.

Reset
REQ-017 rst high at a rising edge SHALL force IDLE regardless of state, dropping any in-flight access with no response; a WRITE not yet reached is never issued.
REQ-018 Reset values: req_ready=1 after release, resp_valid=0, resp_err=0, resp_rdata=0, mem_en=0, mem_rd_wr=1, addresses 0, mem_write_data=0.

Configuration
REQ-019 Macro LSU_MISALIGN_TRAP_EN: defined -> half with addr[0]=1 or word with addr[1:0]!=0 is a fault (resp_err=1, no memory access); undefined -> misaligned low bits silently cleared (half: addr[0]=0; word: addr[1:0]=0) and access proceeds normally, resp_err only for size 11 or range.

Verification
REQ-020 Word store 0xDEADBEEF @0x100, then word load @0x100 -> one WRITE cycle addr 0x100 data 0xDEADBEEF; load resp_rdata=0xDEADBEEF, resp_err=0, latency 2.
REQ-021 Memory word @0x100=0xDEADBEEF; byte store 0x55 @0x102 -> READ @0x100 then WRITE 0xDE55BEEF, resp at cycle 3.
REQ-022 Loads from 0xDE55BEEF: signed byte @0x103 -> 0xFFFFFFDE; unsigned half @0x102 -> 0x0000DE55; signed half @0x100 -> 0xFFFFBEEF.
REQ-023 Word load @0x102 with LSU_MISALIGN_TRAP_EN -> resp_err=1, rdata 0, mem_en never high; without macro -> reads @0x100; word store @0x4000 -> resp_err=1 either build.
REQ-024 Hold resp_ready=0 for 5 cycles -> resp_valid, resp_rdata stable, req_ready=0; assert rst during WRITE-pending READ cycle -> next cycle IDLE, no WRITE, resp_valid=0.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: turns pipeline byte/half/word accesses into word-wide
// memory reads, read-modify-writes and writes with a single access in flight.
// Optional feature macro: LSU_MISALIGN_TRAP_EN. When it is defined, misaligned
// half/word accesses fault. Otherwise the low address bits are cleared and the
// access proceeds.
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. A response transfers on a rising edge where
// resp_valid and resp_ready are both high. A raised valid stays raised with
// stable payload until that transfer.
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_BYTES  = 16384
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_en,
  output logic                  mem_rd_wr,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t                state, state_next;
  logic                  cap_we;
  logic [1:0]            cap_size;
  logic                  cap_uns;
  logic [1:0]            cap_lane;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic [DATA_WIDTH-1:0] merged;

  logic [ADDR_WIDTH-1:0] aligned;
  logic [ADDR_WIDTH:0]   end_addr;
  logic [1:0]            lane;
  logic                  misalign;
  logic                  fault;
  logic                  accept;
  logic [4:0]            shamt;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] load_value;
  logic [DATA_WIDTH-1:0] lane_mask;
  logic [DATA_WIDTH-1:0] merge_word;

  // Decode the incoming request: aligned word address, lane and fault.
  always_comb begin
    aligned  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
    end_addr = {1'b0, aligned} + (ADDR_WIDTH+1)'(4);
`ifdef LSU_MISALIGN_TRAP_EN
    lane     = req_addr[1:0];
    misalign = ((req_size == 2'b01) && req_addr[0]) ||
               ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
    case (req_size)
      2'b01:   lane = {req_addr[1], 1'b0};
      2'b10:   lane = 2'b00;
      default: lane = req_addr[1:0];
    endcase
`endif
    fault  = (req_size == 2'b11) ||
             (end_addr > (ADDR_WIDTH+1)'(MEM_BYTES)) || misalign;
    accept = (state == IDLE) && req_valid;
  end

  // Extract and extend load data, and build the read-modify-write word.
  always_comb begin
    shamt      = {cap_lane, 3'b000};
    shifted    = mem_read_data >> shamt;
    load_value = mem_read_data;
    lane_mask  = DATA_WIDTH'(32'h0000_00FF) << shamt;
    case (cap_size)
      2'b00: load_value = cap_uns ? {24'h0, shifted[7:0]}
                                  : {{24{shifted[7]}}, shifted[7:0]};
      2'b01: load_value = cap_uns ? {16'h0, shifted[15:0]}
                                  : {{16{shifted[15]}}, shifted[15:0]};
      default: load_value = mem_read_data;
    endcase
    if (cap_size == 2'b01) lane_mask = DATA_WIDTH'(32'h0000_FFFF) << shamt;
    merge_word = (mem_read_data & ~lane_mask) | ((cap_wdata << shamt) & lane_mask);
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (req_valid) begin
        if (fault)                             state_next = RESP;
        else if (req_we && req_size == 2'b10)  state_next = WRITE;
        else                                   state_next = READ;
      end
      READ:    state_next = cap_we ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    req_ready      = (state == IDLE);
    resp_valid     = (state == RESP);
    mem_en         = (state == READ) || (state == WRITE);
    mem_rd_wr      = (state != WRITE);
    mem_read_addr  = cap_addr;
    mem_write_addr = cap_addr;
    mem_write_data = (state == WRITE) ? merged : '0;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Request capture, load result and merged-word registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_we     <= 1'b0;
      cap_size   <= 2'b00;
      cap_uns    <= 1'b0;
      cap_lane   <= 2'b00;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      merged     <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (accept) begin
      cap_we     <= req_we;
      cap_size   <= req_size;
      cap_uns    <= req_unsigned;
      cap_lane   <= lane;
      cap_addr   <= aligned;
      cap_wdata  <= req_wdata;
      merged     <= req_wdata;
      resp_rdata <= '0;
      resp_err   <= fault;
    end else if (state == READ) begin
      if (cap_we) merged     <= merge_word;
      else        resp_rdata <= load_value;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte memory model, directed scenarios and
// randomized accesses checked against a byte-array reference model.
module tb_load_store_unit;
  localparam int MB = 16384;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_en, mem_rd_wr;
  logic [31:0] mem_read_addr, mem_write_addr, mem_write_data, mem_read_data;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem     [MB];
  logic [7:0]  ref_mem [MB];
  int          rd_total = 0;
  int          wr_total = 0;
  logic [31:0] last_rd_addr, last_wr_addr, last_wr_data;
  logic [31:0] last_rdata;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_BYTES(MB)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_en(mem_en), .mem_rd_wr(mem_rd_wr), .mem_read_addr(mem_read_addr),
    .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  // Clock.
  always #5 clk = ~clk;

  // Combinational memory read port.
  always @(*) begin
    if (mem_read_addr <= 32'(MB - 4))
      mem_read_data = {mem[mem_read_addr + 3], mem[mem_read_addr + 2],
                       mem[mem_read_addr + 1], mem[mem_read_addr]};
    else
      mem_read_data = 32'h0;
  end

  // Memory write port and access monitor.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_rd_wr) begin
        rd_total     <= rd_total + 1;
        last_rd_addr <= mem_read_addr;
      end else begin
        wr_total     <= wr_total + 1;
        last_wr_addr <= mem_write_addr;
        last_wr_data <= mem_write_data;
        if (mem_write_addr <= 32'(MB - 4))
          for (int i = 0; i < 4; i++) mem[mem_write_addr + i] <= mem_write_data[8*i +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete access through the DUT, checked against the reference model.
  task automatic do_access(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata, input int hold);
    int          n, ea, wa, lat, rd0, wr0, exp_lat;
    logic        flt, mis;
    logic [31:0] exp_rdata, exp_word, held;
    n  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    ea = int'(addr);
`ifdef LSU_MISALIGN_TRAP_EN
    mis = (ea % n) != 0 && size != 2'd3;
`else
    mis = 1'b0;
    if (size != 2'd3) ea = ea - (ea % n);
`endif
    wa  = ea - (ea % 4);
    flt = (size == 2'd3) || (addr > 32'(MB)) || (wa + 4 > MB) || mis;
    exp_rdata = 32'h0;
    exp_word  = 32'h0;
    if (!flt && !we) begin
      for (int i = 0; i < n; i++) exp_rdata = exp_rdata | (32'(ref_mem[ea + i]) << (8 * i));
      if (!uns && n < 4 && exp_rdata[8*n-1]) exp_rdata = exp_rdata | ~((32'h1 << (8 * n)) - 1);
    end
    if (!flt && we) begin
      for (int i = 0; i < n; i++) ref_mem[ea + i] = wdata[8*i +: 8];
      for (int i = 0; i < 4; i++) exp_word = exp_word | (32'(ref_mem[wa + i]) << (8 * i));
    end
    exp_lat = flt ? 1 : (we && n < 4) ? 3 : 2;

    check("req_ready_idle", 32'(req_ready), 32'd1);
    rd0 = rd_total; wr0 = wr_total;
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("resp_err", 32'(resp_err), 32'(flt));
    check("resp_rdata", resp_rdata, exp_rdata);
    check("read_count", 32'(rd_total - rd0), (!flt && (!we || n < 4)) ? 32'd1 : 32'd0);
    check("write_count", 32'(wr_total - wr0), (!flt && we) ? 32'd1 : 32'd0);
    if (!flt && we) begin
      check("write_addr", last_wr_addr, 32'(wa));
      check("write_data", last_wr_data, exp_word);
    end
    if (!flt && (!we || n < 4)) check("read_addr", last_rd_addr, 32'(wa));
    held = resp_rdata;
    last_rdata = resp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_rdata", resp_rdata, held);
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    check("post_resp_valid", 32'(resp_valid), 32'd0);
    check("post_resp_idle", 32'(req_ready), 32'd1);
    check("no_mem_after_resp", 32'(mem_en), 32'd0);
  endtask

  initial begin
    int wr0;
    for (int i = 0; i < MB; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values.
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_rd_wr", 32'(mem_rd_wr), 32'd1);
    check("rst_read_addr", mem_read_addr, 32'h0);
    check("rst_write_addr", mem_write_addr, 32'h0);
    check("rst_write_data", mem_write_data, 32'h0);

    // Word store then load.
    do_access(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 0);
    check("w_store_data", last_wr_data, 32'hDEADBEEF);
    do_access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0);
    check("w_load_data", last_rdata, 32'hDEADBEEF);
    // Byte store read-modify-write.
    do_access(1'b1, 2'd0, 1'b0, 32'h102, 32'h55, 1);
    check("b_store_merge", last_wr_data, 32'hDE55BEEF);
    // Extended loads.
    do_access(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 0);
    check("sb_load", last_rdata, 32'hFFFFFFDE);
    do_access(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 0);
    check("uh_load", last_rdata, 32'h0000DE55);
    do_access(1'b0, 2'd1, 1'b0, 32'h100, 32'h0, 0);
    check("sh_load", last_rdata, 32'hFFFFBEEF);
    // Misaligned word load, out-of-range and boundary accesses, illegal size.
    do_access(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    check("misalign_err", 32'(resp_err), 32'd1);
`else
    check("misalign_word", last_rdata, 32'hDE55BEEF);
`endif
    do_access(1'b1, 2'd2, 1'b0, 32'h4000, 32'h12345678, 0);
    check("range_err", 32'(resp_err), 32'd1);
    do_access(1'b1, 2'd2, 1'b0, 32'h3FFC, 32'hCAFEF00D, 0);
    do_access(1'b0, 2'd0, 1'b1, 32'h3FFF, 32'h0, 0);
    do_access(1'b0, 2'd0, 1'b1, 32'h4000, 32'h0, 0);
    do_access(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 0);
    do_access(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'h0, 0);
    // Long response stall.
    do_access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 5);

    // Reset during the READ of a sub-word store: no WRITE, no response.
    wr0 = wr_total;
    req_we = 1'b1; req_size = 2'd0; req_addr = 32'h104; req_wdata = 32'hAA; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rd_before_rst", 32'(mem_en & mem_rd_wr), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_idle", 32'(req_ready), 32'd1);
    check("rst_mid_valid", 32'(resp_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_no_write", 32'(wr_total - wr0), 32'd0);
    do_access(1'b0, 2'd2, 1'b1, 32'h104, 32'h0, 0);

    // Randomized accesses.
    for (int t = 0; t < 200; t++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      a  = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(MB - 8, MB + 4))
                                       : 32'($urandom_range(0, 63));
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      do_access(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end
endmodule
